mem_copy_engine: RTL

- Bus initiator on the single-port data memory: drives address, write enable and write data; consumes the combinational read data.
- On a start pulse, performs one of two block operations:
  - COPY: copies LEN bytes from SRC to DST.
  - FILL: writes a constant to LEN bytes at DST.
- Reports busy, a one-cycle done pulse and an 8-bit additive checksum of the bytes written.
- Sits between the control/sequencer logic and the data memory, multiplexed onto its port by the caller while busy=1.

---
 rtl/mem_copy_engine.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block COPY/FILL engine driving a single-port data memory
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state;
    logic          mode_r;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW-1:0] len_r;
    logic [DW-1:0] fill_r;
    logic [AW-1:0] idx;
    logic [DW-1:0] data_r;
    logic [AW-1:0] idx_next;

    assign idx_next = idx + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            fill_r   <= '0;
            idx      <= '0;
            data_r   <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        src_r    <= src_addr;
                        dst_r    <= dst_addr;
                        len_r    <= len;
                        fill_r   <= fill_val;
                        idx      <= '0;
                        checksum <= '0;
                        if (len == '0)
                            state <= FIN;
                        else
                            state <= mode ? WR : RD;
                    end
                end
                RD: begin
                    data_r <= mem_rdata;
                    state  <= WR;
                end
                WR: begin
                    // mem_wdata is the byte committed at this edge
                    checksum <= checksum + mem_wdata;
                    idx      <= idx_next;
                    if (idx_next == len_r)
                        state <= FIN;
                    else
                        state <= mode_r ? WR : RD;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port is a pure decode of state so reset removes mem_wr_en immediately
    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (state)
            RD: begin
                mem_addr = src_r + idx;
            end
            WR: begin
                mem_addr  = dst_r + idx;
                mem_wr_en = 1'b1;
                mem_wdata = mode_r ? fill_r : data_r;
            end
            default: begin
                mem_addr  = '0;
                mem_wr_en = 1'b0;
                mem_wdata = '0;
            end
        endcase
    end

    assign busy = (state == RD) || (state == WR);
    assign done = (state == FIN);

endmodule
